// File: rtl/ift_pkg.sv
// Shared information-flow-tracking helpers: taint width, taint type,
// taint merge operator, the X-detection rule and the counter update modes.
package ift_pkg;

    localparam int TAINT_W = 32;

    typedef logic [TAINT_W-1:0] taint_t;

    // Update branch selected on an active clock edge, highest priority first.
    typedef enum logic [1:0] {
        MODE_RST   = 2'd0,
        MODE_LOAD  = 2'd1,
        MODE_COUNT = 2'd2,
        MODE_HOLD  = 2'd3
    } cnt_mode_e;

    // Taint is sticky: anything either operand carries survives the merge.
    function automatic taint_t taint_merge(input taint_t a, input taint_t b);
        return a | b;
    endfunction

    // True when any bit of the (zero-extended) control/data vector is X or Z.
    // Zero extension does not hide an X because the reduction XOR propagates it.
    function automatic logic is_x(input logic [63:0] vec);
        return ((^vec) === 1'bx);
    endfunction

endpackage

// File: rtl/sdffe_cnt_ift_next.sv
// Next-state logic for the taint-tracked load/enable counter.
// Optional feature macro: SDFFE_CNT_SAT_EN (saturate at all-ones, no wrap pulse).
module sdffe_cnt_ift_next
    import ift_pkg::*;
#(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RST_VALUE = {WIDTH{1'b0}}
) (
    input  logic [WIDTH-1:0] cnt,
    input  taint_t           cnt_t,
    input  logic             srst,
    input  taint_t           srst_t,
    input  logic             en,
    input  taint_t           en_t,
    input  logic             load,
    input  taint_t           load_t,
    input  logic [WIDTH-1:0] ld_val,
    input  taint_t           ld_val_t,
    output logic [WIDTH-1:0] cnt_nxt,
    output taint_t           cnt_t_nxt,
    output logic             wrap_nxt,
    output taint_t           wrap_t_nxt
);

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1'b1);

    cnt_mode_e mode_s;
    taint_t    ctrl_t_s;

    // Resolve the branch priority: reset (active-low) over load over enable.
    always_comb begin
        mode_s = MODE_HOLD;
        if (!srst) begin
            mode_s = MODE_RST;
        end else if (load) begin
            mode_s = MODE_LOAD;
        end else if (en) begin
            mode_s = MODE_COUNT;
        end else begin
            mode_s = MODE_HOLD;
        end
    end

    // Compute next value, next taint and the wrap pulse for the selected branch.
    always_comb begin
        ctrl_t_s   = taint_merge(cnt_t, taint_merge(en_t, load_t));
        cnt_nxt    = cnt;
        cnt_t_nxt  = ctrl_t_s;
        wrap_nxt   = 1'b0;
        wrap_t_nxt = ctrl_t_s;

        case (mode_s)
            MODE_RST: begin
                cnt_nxt    = RST_VALUE;
                cnt_t_nxt  = srst_t;
                wrap_t_nxt = srst_t;
            end
            MODE_LOAD: begin
                cnt_nxt   = ld_val;
                cnt_t_nxt = taint_merge(ld_val_t, load_t);
            end
            MODE_COUNT: begin
`ifdef SDFFE_CNT_SAT_EN
                if (cnt == ALL_ONES) begin
                    cnt_nxt = cnt;
                end else begin
                    cnt_nxt = cnt + ONE;
                end
                wrap_nxt = 1'b0;
`else
                cnt_nxt  = cnt + ONE;
                wrap_nxt = (cnt == ALL_ONES);
`endif
            end
            MODE_HOLD: begin
                cnt_nxt = cnt;
            end
            default: begin
                cnt_nxt = cnt;
            end
        endcase

        // A value equal to the reset value is one the reset line could also
        // have produced, so the reset taint flows into it.
        if ((mode_s != MODE_RST) && (cnt_nxt == RST_VALUE)) begin
            cnt_t_nxt = taint_merge(cnt_t_nxt, srst_t);
        end else begin
            cnt_t_nxt = cnt_t_nxt;
        end

        // Unknown control or data: taint is cleared for this update.
        if (is_x(64'({srst, en, load, ld_val}))) begin
            cnt_t_nxt  = {TAINT_W{1'b0}};
            wrap_t_nxt = {TAINT_W{1'b0}};
        end else begin
            wrap_t_nxt = wrap_t_nxt;
        end
    end

endmodule

// File: rtl/sdffe_cnt_ift.sv
// Taint-tracked load/enable counter feeding a sync-reset flip-flop stage.
// All outputs are registered on the CLK_POLARITY edge of CLK.
// Optional feature macro: SDFFE_CNT_SAT_EN (saturate at all-ones, WRAP held at 0).
module sdffe_cnt_ift
    import ift_pkg::*;
#(
    parameter int               WIDTH        = 4,
    parameter logic             CLK_POLARITY = 1'b1,
    parameter logic [WIDTH-1:0] RST_VALUE    = {WIDTH{1'b0}}
) (
    input  logic             CLK,
    input  taint_t           CLK_t,
    input  logic             SRST,
    input  taint_t           SRST_t,
    input  logic             EN,
    input  taint_t           EN_t,
    input  logic             LOAD,
    input  taint_t           LOAD_t,
    input  logic [WIDTH-1:0] LD_VAL,
    input  taint_t           LD_VAL_t,
    output logic [WIDTH-1:0] CNT,
    output taint_t           CNT_t,
    output logic             WRAP,
    output taint_t           WRAP_t
);

    logic [WIDTH-1:0] cnt_r;
    taint_t           cnt_t_r  = {TAINT_W{1'b0}};
    logic             wrap_r;
    taint_t           wrap_t_r = {TAINT_W{1'b0}};

    logic [WIDTH-1:0] cnt_nxt_s;
    taint_t           cnt_t_nxt_s;
    logic             wrap_nxt_s;
    taint_t           wrap_t_nxt_s;

    // Clock taint is accepted for interface uniformity but never propagates.
    logic             unused_clk_t_s;
    assign unused_clk_t_s = ^CLK_t;

    sdffe_cnt_ift_next #(
        .WIDTH     (WIDTH),
        .RST_VALUE (RST_VALUE)
    ) u_next (
        .cnt        (cnt_r),
        .cnt_t      (cnt_t_r),
        .srst       (SRST),
        .srst_t     (SRST_t),
        .en         (EN),
        .en_t       (EN_t),
        .load       (LOAD),
        .load_t     (LOAD_t),
        .ld_val     (LD_VAL),
        .ld_val_t   (LD_VAL_t),
        .cnt_nxt    (cnt_nxt_s),
        .cnt_t_nxt  (cnt_t_nxt_s),
        .wrap_nxt   (wrap_nxt_s),
        .wrap_t_nxt (wrap_t_nxt_s)
    );

    if (CLK_POLARITY) begin : g_pos_edge
        // Capture next state on the rising edge; reset is folded into the next-state logic.
        always_ff @(posedge CLK) begin
            cnt_r    <= cnt_nxt_s;
            cnt_t_r  <= cnt_t_nxt_s;
            wrap_r   <= wrap_nxt_s;
            wrap_t_r <= wrap_t_nxt_s;
        end
    end else begin : g_neg_edge
        // Capture next state on the falling edge; reset is folded into the next-state logic.
        always_ff @(negedge CLK) begin
            cnt_r    <= cnt_nxt_s;
            cnt_t_r  <= cnt_t_nxt_s;
            wrap_r   <= wrap_nxt_s;
            wrap_t_r <= wrap_t_nxt_s;
        end
    end

    assign CNT    = cnt_r;
    assign CNT_t  = cnt_t_r;
    assign WRAP   = wrap_r;
    assign WRAP_t = wrap_t_r;

endmodule

// File: tb/tb_sdffe_cnt_ift.sv
// Directed self-checking bench for sdffe_cnt_ift (WIDTH=4, rising edge, RST_VALUE=0).
// Expected values follow the modulo build unless SDFFE_CNT_SAT_EN is defined.
module tb_sdffe_cnt_ift;

`ifdef SDFFE_CNT_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic [31:0] CLK_t = 32'h0;
    logic        SRST;
    logic [31:0] SRST_t;
    logic        EN;
    logic [31:0] EN_t;
    logic        LOAD;
    logic [31:0] LOAD_t;
    logic [3:0]  LD_VAL;
    logic [31:0] LD_VAL_t;
    logic [3:0]  CNT;
    logic [31:0] CNT_t;
    logic        WRAP;
    logic [31:0] WRAP_t;

    int checks   = 0;
    int failures = 0;
    logic probe_x;
    bit   four_state;

    sdffe_cnt_ift #(
        .WIDTH        (4),
        .CLK_POLARITY (1'b1),
        .RST_VALUE    (4'h0)
    ) dut (
        .CLK      (CLK),
        .CLK_t    (CLK_t),
        .SRST     (SRST),
        .SRST_t   (SRST_t),
        .EN       (EN),
        .EN_t     (EN_t),
        .LOAD     (LOAD),
        .LOAD_t   (LOAD_t),
        .LD_VAL   (LD_VAL),
        .LD_VAL_t (LD_VAL_t),
        .CNT      (CNT),
        .CNT_t    (CNT_t),
        .WRAP     (WRAP),
        .WRAP_t   (WRAP_t)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic srst, input logic [31:0] srst_t,
                         input logic en, input logic [31:0] en_t,
                         input logic load, input logic [31:0] load_t,
                         input logic [3:0] ld_val, input logic [31:0] ld_val_t);
        SRST = srst; SRST_t = srst_t; EN = en; EN_t = en_t;
        LOAD = load; LOAD_t = load_t; LD_VAL = ld_val; LD_VAL_t = ld_val_t;
    endtask

    initial begin
        probe_x    = 1'bx;
        four_state = (probe_x === 1'bx);
        drive(1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);
        #1;
        chk("powerup_cnt_t",  CNT_t,  32'h0);
        chk("powerup_wrap_t", WRAP_t, 32'h0);

        // Reset edge.
        drive(1'b0, 32'h1, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);
        tick();
        chk("rst_cnt",    32'(CNT),  32'h0);
        chk("rst_cnt_t",  CNT_t,     32'h1);
        chk("rst_wrap",   32'(WRAP), 32'h0);
        chk("rst_wrap_t", WRAP_t,    32'h1);

        // Load 4'hE.
        #3 drive(1'b1, 32'h20, 1'b0, 32'h0, 1'b1, 32'h8, 4'hE, 32'h4);
        tick();
        chk("load_cnt",    32'(CNT), 32'hE);
        chk("load_cnt_t",  CNT_t,    32'hC);
        chk("load_wrap_t", WRAP_t,   32'h9);

        // Count E -> F.
        #3 drive(1'b1, 32'h20, 1'b1, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);
        tick();
        chk("count_cnt",   32'(CNT), 32'hF);
        chk("count_cnt_t", CNT_t,    32'hC);

        // Hold.
        #3 EN = 1'b0;
        tick();
        chk("hold_cnt",   32'(CNT), 32'hF);
        chk("hold_cnt_t", CNT_t,    32'hC);

        // Enable from all-ones with EN_t: wrap (or saturate).
        #3 drive(1'b1, 32'h20, 1'b1, 32'h10, 1'b0, 32'h0, 4'h0, 32'h0);
        tick();
        chk("wrap_cnt",    32'(CNT),  SAT ? 32'hF : 32'h0);
        chk("wrap_pulse",  32'(WRAP), SAT ? 32'h0 : 32'h1);
        chk("wrap_cnt_t",  CNT_t,     SAT ? 32'h1C : 32'h3C);
        chk("wrap_wrap_t", WRAP_t,    32'h1C);

        // Wrap pulse lasts one cycle.
        #3 EN_t = 32'h0;
        tick();
        chk("post_wrap_cnt",  32'(CNT),  SAT ? 32'hF : 32'h1);
        chk("post_wrap_pulse", 32'(WRAP), 32'h0);
        tick();
        chk("third_en_cnt",  32'(CNT),  SAT ? 32'hF : 32'h2);
        chk("third_en_wrap", 32'(WRAP), 32'h0);

        // Reset beats load and enable on the same edge.
        #3 drive(1'b0, 32'h1, 1'b1, 32'h0, 1'b1, 32'h0, 4'h7, 32'h0);
        tick();
        chk("prio_cnt",   32'(CNT),  32'h0);
        chk("prio_wrap",  32'(WRAP), 32'h0);
        chk("prio_cnt_t", CNT_t,     32'h1);

        // Load all-ones, then enable wraps to 0.
        #3 drive(1'b1, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0, 4'hF, 32'h2);
        tick();
        chk("ldf_cnt",    32'(CNT), 32'hF);
        chk("ldf_wrap_t", WRAP_t,   32'h1);
        #3 drive(1'b1, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);
        tick();
        chk("ldf_en_cnt",  32'(CNT),  SAT ? 32'hF : 32'h0);
        chk("ldf_en_wrap", 32'(WRAP), SAT ? 32'h0 : 32'h1);
        chk("ldf_en_cnt_t", CNT_t,    32'h2);

        // Reset mid-operation drops a pending wrap.
        #3 drive(1'b1, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0, 4'hF, 32'h2);
        tick();
        #3 drive(1'b0, 32'h40, 1'b1, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);
        tick();
        chk("midrst_cnt",    32'(CNT),  32'h0);
        chk("midrst_wrap",   32'(WRAP), 32'h0);
        chk("midrst_cnt_t",  CNT_t,     32'h40);
        chk("midrst_wrap_t", WRAP_t,    32'h40);

        // Loading the reset value picks up the reset taint.
        #3 drive(1'b1, 32'h80, 1'b0, 32'h0, 1'b1, 32'h1, 4'h0, 32'h0);
        tick();
        chk("ld_rstval_cnt_t",  CNT_t,  32'h81);
        chk("ld_rstval_wrap_t", WRAP_t, 32'h41);

        // Unknown load value clears taint (only observable on a 4-state simulator).
        #3 drive(1'b1, 32'h0, 1'b0, 32'h0, 1'b1, 32'h8, 4'bx1x0, 32'h4);
        tick();
        chk("x_cnt_t",  CNT_t,  four_state ? 32'h0 : 32'hC);
        chk("x_wrap_t", WRAP_t, four_state ? 32'h0 : 32'h89);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
